// File: rtl/wb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : wb_deserializer
// Purpose  : Receive side of the serial link. Samples data_i on cycles where
//            ena_i=1, rebuilds 27-bit frames (three 9-bit symbols, MSB first)
//            and queues them in a small FIFO read over a Wishbone slave port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_I   in   1   clock
//   RST_NI  in   1   asynchronous reset, active low
//   data_i  in   1   serial data, MSB of frame first
//   ena_i   in   1   data_i valid this cycle
//   CYC_I   in   1   WB cycle
//   STB_I   in   1   WB strobe
//   WE_I    in   1   WB write enable
//   ADR_I   in   32  WB address, [1:0]: 0 DATA(R), 1 STATUS(R), 2 CTRL(W)
//   DAT_I   in   32  WB write data (CTRL: bit0 flush, bit1 clear ovf/tmo)
//   ACK_O   out  1   WB acknowledge (combinational)
//   ERR_O   out  1   WB error (combinational)
//   DAT_O   out  32  WB read data (combinational)
// Configuration macro
//   DESER_TIMEOUT_EN : enables the mid-frame idle timeout and STATUS.tmo.
// ============================================================================
module wb_deserializer #(
    parameter int FRAME_BITS     = 27,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        data_i,
    input  logic        ena_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);

    // Elaboration-time guard on the supported configuration space.
    if (FRAME_BITS != 27 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_deserializer: unsupported parameter set");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RX   = 1'b1
    } state_t;

    state_t               r_state;
    logic [4:0]           r_cnt;
    logic [25:0]          r_shreg;
    logic [26:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_ovf;
    logic                 r_tmo;

    logic                 w_req;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_clr;
    logic                 w_done;
    logic                 w_push;
    logic                 w_ovf_evt;
    logic                 w_tmo_evt;
    logic [26:0]          w_frame;
    logic [31:0]          w_status;
    logic                 w_unused;

    assign w_unused = ^{ADR_I[31:2], DAT_I[31:2]};

    assign w_req    = CYC_I & STB_I;
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_frame  = {r_shreg, data_i};
    assign w_status = {16'b0, 8'(r_level), 4'b0, r_tmo, r_ovf, w_full, w_empty};

    // Frame completes on the 27th valid bit; a concurrent flush discards it.
    assign w_done    = ena_i && (r_cnt == 5'd26);
    // A pop in the same cycle frees a slot before the push lands.
    assign w_push    = w_done && !w_flush && (!w_full || w_pop);
    assign w_ovf_evt = w_done && !w_flush && w_full && !w_pop;

    // ------------------------------------------------------------------
    // Wishbone decode: single-cycle combinational response.
    // ------------------------------------------------------------------
    always_comb begin
        ACK_O   = 1'b0;
        ERR_O   = 1'b0;
        DAT_O   = 32'b0;
        w_pop   = 1'b0;
        w_flush = 1'b0;
        w_clr   = 1'b0;
        if (w_req) begin
            case (ADR_I[1:0])
                2'd0: begin
                    if (!WE_I && !w_empty) begin
                        ACK_O = 1'b1;
                        DAT_O = {5'b0, r_mem[r_rptr]};
                        w_pop = 1'b1;
                    end else begin
                        ERR_O = 1'b1;
                    end
                end
                2'd1: begin
                    if (!WE_I) begin
                        ACK_O = 1'b1;
                        DAT_O = w_status;
                    end else begin
                        ERR_O = 1'b1;
                    end
                end
                2'd2: begin
                    if (WE_I) begin
                        ACK_O   = 1'b1;
                        w_flush = DAT_I[0];
                        w_clr   = DAT_I[1];
                    end else begin
                        ERR_O = 1'b1;
                    end
                end
                default: ERR_O = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional mid-frame idle timeout.
    // ------------------------------------------------------------------
`ifdef DESER_TIMEOUT_EN
    localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_IDLE_W-1:0] r_idle;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
    assign w_tmo_evt = (r_state == S_RX) && !ena_i &&
                       (r_idle == c_IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_idle <= '0;
        end else if (r_state == S_IDLE || ena_i || w_flush || w_tmo_evt) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_tmo_evt = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Receive FSM, FIFO pointers and sticky flags.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_shreg <= 26'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            if (w_flush) begin
                r_state <= S_IDLE;
                r_cnt   <= 5'd0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (ena_i) begin
                            r_shreg <= {r_shreg[24:0], data_i};
                            r_cnt   <= 5'd1;
                            r_state <= S_RX;
                        end
                    end
                    S_RX: begin
                        if (w_tmo_evt) begin
                            r_cnt   <= 5'd0;
                            r_state <= S_IDLE;
                        end else if (ena_i) begin
                            r_shreg <= {r_shreg[24:0], data_i};
                            if (w_done) begin
                                r_cnt   <= 5'd0;
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_cnt   <= 5'd0;
                        r_state <= S_IDLE;
                    end
                endcase

                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end

            // New events take priority over a software clear.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_tmo_evt) begin
                r_tmo <= 1'b1;
            end else if (w_clr) begin
                r_tmo <= 1'b0;
            end
        end
    end

    // Frame storage carries no reset; contents are only visible when level>0.
    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_frame;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_deserializer
// Purpose  : Directed self-checking bench for wb_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_deserializer;

    logic        CLK_I = 1'b0;
    logic        RST_NI;
    logic        data_i;
    logic        ena_i;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;

    int n_pass  = 0;
    int n_total = 0;

    wb_deserializer #(
        .FRAME_BITS     (27),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .CLK_I  (CLK_I),
        .RST_NI (RST_NI),
        .data_i (data_i),
        .ena_i  (ena_i),
        .CYC_I  (CYC_I),
        .STB_I  (STB_I),
        .WE_I   (WE_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .ACK_O  (ACK_O),
        .ERR_O  (ERR_O),
        .DAT_O  (DAT_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit later.
    task automatic send_bits(input logic [26:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            data_i = v[i];
            ena_i  = 1'b1;
            @(posedge CLK_I);
            #1;
            ena_i  = 1'b0;
            data_i = 1'b0;
            if (gap > 0 && (i % 7) == 0) begin
                repeat (gap) @(posedge CLK_I);
                #1;
            end
        end
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] dat,
                           output logic ack, output logic err);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = {30'b0, adr};
        #1;
        dat = DAT_O; ack = ACK_O; err = ERR_O;
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; ADR_I = 32'b0;
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] d,
                            output logic ack, output logic err);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = {30'b0, adr}; DAT_I = d;
        #1;
        ack = ACK_O; err = ERR_O;
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 32'b0; DAT_I = 32'b0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        logic a, e;
        wb_read(2'd1, d, a, e);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
        check(tag, d, exp);
    endtask

    task automatic read_frame(input string tag, input logic [26:0] exp);
        logic [31:0] d;
        logic a, e;
        wb_read(2'd0, d, a, e);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
        check(tag, d, {5'b0, exp});
    endtask

    task automatic ctrl(input string tag, input logic [31:0] d);
        logic a, e;
        wb_write(2'd2, d, a, e);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        a, e;
        logic [26:0] frames [5];
        logic [26:0] f_a, f_b;
        logic [9:0]  pre;

        frames[0] = 27'h1234567;
        frames[1] = 27'h0ABCDEF;
        frames[2] = 27'h7FFFFFF;
        frames[3] = 27'h0000001;
        frames[4] = 27'h4000000;
        f_a = 27'h5A5A5A5;
        f_b = 27'h3C0FF00;
        pre = 10'h2B5;

        RST_NI = 1'b0; data_i = 1'b0; ena_i = 1'b0;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 32'b0; DAT_I = 32'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        check("idle_ack", {31'b0, ACK_O}, 32'd0);
        check("idle_err", {31'b0, ERR_O}, 32'd0);
        check("idle_dat", DAT_O, 32'd0);
        RST_NI = 1'b1;
        check_status("rst_status", 32'h00000001);

        // 1: symbols 0x0A5, 0x03C, 0x1BC with gaps
        send_bits({9'h0A5, 9'h03C, 9'h1BC}, 27, 3);
        check_status("t1_status", 32'h00000100);
        read_frame("t1_data", 27'h29479BC);
        check_status("t1_status2", 32'h00000001);

        // 2: illegal accesses
        wb_read(2'd0, d, a, e);
        check("t2_rd_empty_err", {31'b0, e}, 32'd1);
        check("t2_rd_empty_ack", {31'b0, a}, 32'd0);
        check("t2_rd_empty_dat", d, 32'd0);
        wb_write(2'd0, 32'hFFFFFFFF, a, e);
        check("t2_wr_data_err", {30'b0, a, e}, 32'd1);
        wb_write(2'd1, 32'h0, a, e);
        check("t2_wr_stat_err", {30'b0, a, e}, 32'd1);
        wb_read(2'd2, d, a, e);
        check("t2_rd_ctrl_err", {30'b0, a, e}, 32'd1);
        wb_read(2'd3, d, a, e);
        check("t2_rd_adr3_err", {30'b0, a, e}, 32'd1);
        check_status("t2_status", 32'h00000001);

        // 3: overflow with 5 frames into depth 4
        for (int i = 0; i < 5; i++) send_bits(frames[i], 27, 0);
        check_status("t3_status_full", 32'h00000406);
        for (int i = 0; i < 4; i++) read_frame($sformatf("t3_data%0d", i), frames[i]);
        check_status("t3_status_drained", 32'h00000005);
        ctrl("t3_clr", 32'd2);
        check_status("t3_status_clr", 32'h00000001);

        // 4: flush a partial frame
        send_bits(27'h0000155, 10, 0);
        ctrl("t4_flush", 32'd1);
        send_bits(f_a, 27, 0);
        check_status("t4_status", 32'h00000100);
        read_frame("t4_data", f_a);

        // 5: mid-frame idle
        send_bits({17'b0, pre}, 10, 0);
        repeat (64) @(posedge CLK_I);
        #1;
`ifdef DESER_TIMEOUT_EN
        check_status("t5_status_tmo", 32'h00000009);
        send_bits(f_a, 27, 0);
        read_frame("t5_data", f_a);
        ctrl("t5_clr", 32'd2);
        check_status("t5_status_clr", 32'h00000001);
`else
        check_status("t5_status_notmo", 32'h00000001);
        send_bits(f_a, 27, 0);
        check_status("t5_status_mis", 32'h00000100);
        read_frame("t5_data_mis", {pre, f_a[26:10]});
        ctrl("t5_flush", 32'd1);
        check_status("t5_status_flush", 32'h00000001);
`endif

        // Simultaneous pop and push while full: no overflow
        for (int i = 0; i < 4; i++) send_bits(frames[i], 27, 0);
        send_bits(frames[4] >> 1, 26, 0);
        data_i = frames[4][0]; ena_i = 1'b1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'd0;
        #1;
        d = DAT_O; a = ACK_O;
        @(posedge CLK_I);
        #1;
        ena_i = 1'b0; data_i = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
        check("pp_ack", {31'b0, a}, 32'd1);
        check("pp_data", d, {5'b0, frames[0]});
        check_status("pp_status", 32'h00000402);
        for (int i = 1; i < 5; i++) read_frame($sformatf("pp_data%0d", i), frames[i]);
        check_status("pp_status2", 32'h00000001);

        // Flush coinciding with frame completion: frame dropped, no ovf
        send_bits(f_b >> 1, 26, 0);
        data_i = f_b[0]; ena_i = 1'b1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'd2; DAT_I = 32'd1;
        #1;
        a = ACK_O;
        @(posedge CLK_I);
        #1;
        ena_i = 1'b0; data_i = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ADR_I = 32'd0; DAT_I = 32'd0;
        check("fc_ack", {31'b0, a}, 32'd1);
        check_status("fc_status", 32'h00000001);
        send_bits(f_b, 27, 0);
        read_frame("fc_data", f_b);

        // 6: async reset mid-frame with 2 frames queued
        send_bits(frames[0], 27, 0);
        send_bits(frames[1], 27, 0);
        check_status("t6_status_pre", 32'h00000200);
        send_bits(27'h000001B, 5, 0);
        #2;
        RST_NI = 1'b0;
        #1;
        check_status("t6_status_rst", 32'h00000001);
        RST_NI = 1'b1;
        send_bits(f_b, 27, 0);
        check_status("t6_status_post", 32'h00000100);
        read_frame("t6_data", f_b);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
